// File: rtl/led_bank_arbiter_if.sv
// LED bank arbiter bus: requester requests/patterns, PWM duty, and the
// arbitrated grant/busy/LED outputs. The master side is the fabric (pattern
// sources); the slave side is the arbiter itself.
interface led_bank_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 24,
   parameter int DUTY_WIDTH = 3
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [DUTY_WIDTH-1:0]         duty;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;
   logic [DATA_WIDTH-1:0]         led;

   modport master (
      output req, req_data, duty,
      input  grant, busy, led
   );

   modport slave (
      input  req, req_data, duty,
      output grant, busy, led
   );
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin ownership of the active-low LED bank with a
// minimum hold time per owner, plus a global PWM brightness duty applied to
// the owner's pattern before the registered LED drive.
// Optional build macro LED_ARB_PREEMPT_EN: requester 0 becomes a debug
// override that preempts any other owner and is never handed off on hold
// expiry. Undefined, requester 0 is an ordinary round-robin participant.
module led_bank_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int DATA_WIDTH  = 24,
   parameter int HOLD_CYCLES = 6000000,
   parameter int DUTY_WIDTH  = 3
) (
   input  logic              clk_12mhz,
   input  logic              rst,
   led_bank_arbiter_if.slave bus
);
   localparam int OWNER_W = $clog2(NUM_REQ);
   localparam int HOLD_W  = $clog2(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [OWNER_W-1:0] LAST_IDX    = OWNER_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, ARB, OWN} state_t;

   state_t                  state_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic                    busy_q;
   logic [DATA_WIDTH-1:0]   led_q;
   logic [OWNER_W-1:0]      last_owner_q;
   logic [HOLD_W-1:0]       hold_cnt_q;
   logic [DUTY_WIDTH-1:0]   pwm_cnt_q;

   logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
   logic [OWNER_W-1:0]      rr_cand;
   logic                    rr_found;
   logic [OWNER_W-1:0]      winner_d;
   logic [NUM_REQ-1:0]      winner_onehot_d;
   logic                    owner_req;
   logic                    others_req;
   logic                    pwm_on;

   // Split the flat pattern bus into one word per requester.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Round-robin pick: first set request after last_owner, the previous
   // owner itself being scanned last.
   always_comb begin
      rr_cand  = last_owner_q;
      rr_found = 1'b0;
      winner_d = last_owner_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_cand = OWNER_W'((int'(last_owner_q) + k) % NUM_REQ);
         if (!rr_found && bus.req[rr_cand]) begin
            rr_found = 1'b1;
            winner_d = rr_cand;
         end
      end
`ifdef LED_ARB_PREEMPT_EN
      // The debug requester wins arbitration unconditionally.
      if (bus.req[0]) begin
         winner_d = '0;
      end
`endif
   end

   assign winner_onehot_d = NUM_REQ'(1) << winner_d;

   // The owner is always last_owner while a grant is held.
   assign owner_req  = bus.req[last_owner_q];
   assign others_req = |(bus.req & ~grant_q);
   assign pwm_on     = (bus.duty == {DUTY_WIDTH{1'b1}}) | (pwm_cnt_q < bus.duty);

   // Ownership FSM with registered grant/busy and the hold counter.
   always_ff @(posedge clk_12mhz) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         last_owner_q <= LAST_IDX;
         hold_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               if (|bus.req) begin
                  state_q <= ARB;
               end
            end
            ARB: begin
               if (|bus.req) begin
                  grant_q      <= winner_onehot_d;
                  busy_q       <= 1'b1;
                  last_owner_q <= winner_d;
                  hold_cnt_q   <= HOLD_RELOAD;
                  state_q      <= OWN;
               end else begin
                  state_q <= IDLE;
               end
            end
            OWN: begin
               if (!owner_req) begin
                  // Voluntary release ignores the remaining hold time.
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
`ifdef LED_ARB_PREEMPT_EN
               else if (bus.req[0] && !grant_q[0]) begin
                  // Debug override takes the bank away immediately.
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ARB;
               end else if (grant_q[0]) begin
                  // Debug owner is never handed off; hold just saturates.
                  if (hold_cnt_q != '0) begin
                     hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                  end
               end
`endif
               else if (hold_cnt_q == '0) begin
                  if (others_req) begin
                     // One-cycle gap, then re-arbitrate past this owner.
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= ARB;
                  end else begin
                     hold_cnt_q <= HOLD_RELOAD;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Free-running PWM frame counter.
   always_ff @(posedge clk_12mhz) begin
      if (rst) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + DUTY_WIDTH'(1);
      end
   end

   // LED drive register: owner pattern during PWM on-time, else all off.
   always_ff @(posedge clk_12mhz) begin
      if (rst) begin
         led_q <= '1;
      end else if ((grant_q != '0) && pwm_on) begin
         led_q <= data_arr[last_owner_q];
      end else begin
         led_q <= '1;
      end
   end

   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
   assign bus.led   = led_q;
endmodule
